// File: rtl/usb_tx_line_driver.sv
// USB full-speed transmit line driver: serialises encoder bytes LSB first,
// inserts bit stuffing, NRZI-encodes onto dplus/dminus and finishes with SE0/SE0/J.
module usb_tx_line_driver #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       begin_packet,
  input  logic [7:0] shift_data,
  input  logic       is_eop,
  output logic       rollover_flag,
  output logic       dplus,
  output logic       dminus,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  // rollover_flag is registered, so it is launched one cycle before timer==CLKS_PER_BIT-2
  localparam logic [TW-1:0] TIMER_ROLL = TW'(CLKS_PER_BIT - 3);

  // Line encodings as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, EOP_SE0, EOP_J} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [2:0]      ones_cnt_reg, ones_cnt_next;
  logic            stuff_reg, stuff_next;
  logic [7:0]      shift_reg, shift_next;
  logic [1:0]      line_reg, line_next;
  logic            rollover_reg, rollover_next;
  logic            tx_active_reg, tx_active_next;
  logic            tx_done_reg, tx_done_next;

  logic            bit_boundary;
  logic            stuff_due;
  logic            byte_end;
  logic [2:0]      bit_cnt_inc;
  logic [TW-1:0]   timer_wrap;

  // NRZI: a 0 toggles the line between J and K, a 1 holds it
  function automatic logic [1:0] nrzi(input logic b, input logic [1:0] line);
    return b ? line : ~line;
  endfunction

  assign bit_boundary = (timer_reg == TIMER_LAST);
  // Six 1s have just been sent and the current period is not already a stuffed bit
  assign stuff_due    = !stuff_reg && (ones_cnt_reg == 3'd6);
  // Current period is the last one of the byte (bit 7 with no stuff pending, or its stuffed bit)
  assign byte_end     = (bit_cnt_reg == 3'd7) && !stuff_due;
  assign bit_cnt_inc  = bit_cnt_reg + 3'd1;
  assign timer_wrap   = bit_boundary ? '0 : timer_reg + TW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; EOP_SE0 reuses bit_cnt to count its two periods
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (begin_packet) state_next = LOAD;
      LOAD:    state_next = is_eop ? EOP_SE0 : SEND;
      SEND:    if (bit_boundary && byte_end && is_eop) state_next = EOP_SE0;
      EOP_SE0: if (bit_boundary && bit_cnt_reg == 3'd1) state_next = EOP_J;
      EOP_J:   if (bit_boundary) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values; every line change lands on a period start
  always_comb begin
    timer_next     = timer_reg;
    bit_cnt_next   = bit_cnt_reg;
    ones_cnt_next  = ones_cnt_reg;
    stuff_next     = stuff_reg;
    shift_next     = shift_reg;
    line_next      = line_reg;
    rollover_next  = 1'b0;
    tx_done_next   = 1'b0;
    tx_active_next = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        timer_next    = '0;
        bit_cnt_next  = '0;
        ones_cnt_next = '0;
        stuff_next    = 1'b0;
        line_next     = LINE_J;
      end
      LOAD: begin
        timer_next   = '0;
        bit_cnt_next = '0;
        stuff_next   = 1'b0;
        shift_next   = shift_data;
        if (is_eop) begin
          line_next     = LINE_SE0;
          ones_cnt_next = '0;
        end else begin
          line_next     = nrzi(shift_data[0], line_reg);
          ones_cnt_next = shift_data[0] ? 3'd1 : 3'd0;
        end
      end
      SEND: begin
        timer_next    = timer_wrap;
        rollover_next = (timer_reg == TIMER_ROLL) && byte_end;
        if (bit_boundary) begin
          if (stuff_due) begin
            stuff_next    = 1'b1;
            line_next     = ~line_reg;
            ones_cnt_next = '0;
          end else if (byte_end) begin
            stuff_next   = 1'b0;
            bit_cnt_next = '0;
            if (is_eop) begin
              line_next     = LINE_SE0;
              ones_cnt_next = '0;
            end else begin
              shift_next    = shift_data;
              line_next     = nrzi(shift_data[0], line_reg);
              ones_cnt_next = shift_data[0] ? ones_cnt_reg + 3'd1 : 3'd0;
            end
          end else begin
            stuff_next    = 1'b0;
            bit_cnt_next  = bit_cnt_inc;
            line_next     = nrzi(shift_reg[bit_cnt_inc], line_reg);
            ones_cnt_next = shift_reg[bit_cnt_inc] ? ones_cnt_reg + 3'd1 : 3'd0;
          end
        end
      end
      EOP_SE0: begin
        timer_next = timer_wrap;
        if (bit_boundary) begin
          if (bit_cnt_reg == 3'd1) begin
            bit_cnt_next = '0;
            line_next    = LINE_J;
          end else begin
            bit_cnt_next = bit_cnt_inc;
          end
        end
      end
      EOP_J: begin
        timer_next = timer_wrap;
        line_next  = LINE_J;
        if (bit_boundary) tx_done_next = 1'b1;
      end
      default: line_next = LINE_J;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg     <= '0;
      bit_cnt_reg   <= '0;
      ones_cnt_reg  <= '0;
      stuff_reg     <= 1'b0;
      shift_reg     <= '0;
      line_reg      <= LINE_J;
      rollover_reg  <= 1'b0;
      tx_active_reg <= 1'b0;
      tx_done_reg   <= 1'b0;
    end else begin
      timer_reg     <= timer_next;
      bit_cnt_reg   <= bit_cnt_next;
      ones_cnt_reg  <= ones_cnt_next;
      stuff_reg     <= stuff_next;
      shift_reg     <= shift_next;
      line_reg      <= line_next;
      rollover_reg  <= rollover_next;
      tx_active_reg <= tx_active_next;
      tx_done_reg   <= tx_done_next;
    end
  end

  assign dplus         = line_reg[1];
  assign dminus        = line_reg[0];
  assign rollover_flag = rollover_reg;
  assign tx_active     = tx_active_reg;
  assign tx_done       = tx_done_reg;

endmodule
